// File: rtl/vga_timing_pkg.sv
// VGA 640x480@60 timing constants and shared types for the stream sink.
// Holds raw porch/sync widths, the derived totals and sync positions, the
// default pixel/FIFO widths and the stream-alignment state type.
package vga_timing_pkg;

    localparam int unsigned DW       = 24;
    localparam int unsigned FIFO_AW  = 4;

    localparam int unsigned H_ACTIVE = 640;
    localparam int unsigned H_FRONT  = 16;
    localparam int unsigned H_SYNC   = 96;
    localparam int unsigned H_BACK   = 48;
    localparam int unsigned V_ACTIVE = 480;
    localparam int unsigned V_FRONT  = 10;
    localparam int unsigned V_SYNC   = 2;
    localparam int unsigned V_BACK   = 33;

    localparam int unsigned H_TOTAL  = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;  // 800
    localparam int unsigned V_TOTAL  = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;  // 525
    localparam int unsigned HS_START = H_ACTIVE + H_FRONT;                    // 656
    localparam int unsigned HS_END   = HS_START + H_SYNC - 1;                 // 751
    localparam int unsigned VS_START = V_ACTIVE + V_FRONT;                    // 490
    localparam int unsigned VS_END   = VS_START + V_SYNC - 1;                 // 491

    typedef enum logic [1:0] {
        StSeek,
        StWaitFrame,
        StRun
    } state_e;

endpackage

// File: rtl/vga_stream_sink_if.sv
// Avalon-ST video stream bundle.
//   master: drives data/startofpacket/endofpacket/empty/valid, samples ready.
//   slave : samples the payload and valid, drives ready.
interface vga_stream_sink_if #(
    parameter int unsigned Dw = vga_timing_pkg::DW
);
    logic [Dw-1:0] data;
    logic          startofpacket;
    logic          endofpacket;
    logic          empty;
    logic          valid;
    logic          ready;

    modport master (
        output data, startofpacket, endofpacket, empty, valid,
        input  ready
    );

    modport slave (
        input  data, startofpacket, endofpacket, empty, valid,
        output ready
    );
endinterface

// File: rtl/stream_fifo.sv
// Synchronous show-ahead FIFO, depth 2**Aw.
//   clk, reset  : clock, synchronous active-low reset (empties the FIFO)
//   wr_en       : push wr_data (ignored when full)
//   rd_en       : pop head (ignored when empty)
//   head        : current head word, valid whenever empty is low
//   full, empty : occupancy flags for the current cycle
//   wr_ready    : registered copy of !full for the next cycle, 0 in reset
module stream_fifo #(
    parameter int unsigned Width = 26,
    parameter int unsigned Aw    = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [Width-1:0] wr_data,
    input  logic             rd_en,
    output logic [Width-1:0] head,
    output logic             full,
    output logic             empty,
    output logic             wr_ready
);
    localparam int unsigned Depth = 2 ** Aw;

    logic [Width-1:0] mem_q [Depth];
    logic [Aw-1:0]    wr_ptr_q, rd_ptr_q;
    logic [Aw:0]      cnt_q, cnt_d;
    logic             wr_ready_q;
    logic             do_wr, do_rd;

    assign full     = (cnt_q == (Aw + 1)'(Depth));
    assign empty    = (cnt_q == '0);
    assign do_wr    = wr_en && !full;
    assign do_rd    = rd_en && !empty;
    assign head     = mem_q[rd_ptr_q];
    assign wr_ready = wr_ready_q;

    always_comb begin
        cnt_d = cnt_q;
        if (do_wr && !do_rd) begin
            cnt_d = cnt_q + 1'b1;
        end else if (!do_wr && do_rd) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            wr_ready_q <= 1'b0;
        end else begin
            if (do_wr) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_rd) rd_ptr_q <= rd_ptr_q + 1'b1;
            cnt_q      <= cnt_d;
            // Ready is registered, so it must look at next-cycle occupancy.
            wr_ready_q <= (cnt_d != (Aw + 1)'(Depth));
        end
    end

    // Storage needs no reset: pointers define what is valid.
    always_ff @(posedge clk) begin
        if (do_wr) mem_q[wr_ptr_q] <= wr_data;
    end

endmodule

// File: rtl/vga_stream_sink.sv
// Final VGA stage: buffers an Avalon-ST pixel stream, locks each packet's SOP
// to raster position (0,0) and drives the DAC pins.
//   clk, reset        : pixel clock, synchronous active-low reset
//   in_st             : stream input (slave side, ready is registered)
//   vga_r/g/b         : colour, black outside the visible area or when unlocked
//   vga_hs, vga_vs    : active-low syncs
//   vga_blank_n       : high during the visible region
//   underflow         : one-cycle pulse, FIFO empty at a visible pixel while locked
//   sync_err          : one-cycle pulse, SOP present/absent at the wrong pixel
// All pin outputs are registered and reflect the raster position one cycle earlier.
module vga_stream_sink
    import vga_timing_pkg::*;
#(
    parameter int unsigned Dw      = DW,
    parameter int unsigned HActive = H_ACTIVE,
    parameter int unsigned HFront  = H_FRONT,
    parameter int unsigned HSync   = H_SYNC,
    parameter int unsigned HBack   = H_BACK,
    parameter int unsigned VActive = V_ACTIVE,
    parameter int unsigned VFront  = V_FRONT,
    parameter int unsigned VSync   = V_SYNC,
    parameter int unsigned VBack   = V_BACK,
    parameter int unsigned FifoAw  = FIFO_AW
) (
    input  logic                clk,
    input  logic                reset,
    vga_stream_sink_if.slave    in_st,
    output logic [7:0]          vga_r,
    output logic [7:0]          vga_g,
    output logic [7:0]          vga_b,
    output logic                vga_hs,
    output logic                vga_vs,
    output logic                vga_blank_n,
    output logic                underflow,
    output logic                sync_err
);
    localparam int unsigned HTotal = HActive + HFront + HSync + HBack;
    localparam int unsigned VTotal = VActive + VFront + VSync + VBack;
    localparam int unsigned Hw     = $clog2(HTotal);
    localparam int unsigned Vw     = $clog2(VTotal);

    localparam logic [Hw-1:0] HLast    = Hw'(HTotal - 1);
    localparam logic [Vw-1:0] VLast    = Vw'(VTotal - 1);
    localparam logic [Hw-1:0] HActC    = Hw'(HActive);
    localparam logic [Vw-1:0] VActC    = Vw'(VActive);
    localparam logic [Hw-1:0] HsStartC = Hw'(HActive + HFront);
    localparam logic [Hw-1:0] HsEndC   = Hw'(HActive + HFront + HSync - 1);
    localparam logic [Vw-1:0] VsStartC = Vw'(VActive + VFront);
    localparam logic [Vw-1:0] VsEndC   = Vw'(VActive + VFront + VSync - 1);

    logic [Hw-1:0] h_cnt_q, h_cnt_d;
    logic [Vw-1:0] v_cnt_q, v_cnt_d;
    logic          h_last, frame_last, visible, at_origin;

    state_e        state_q, state_d;
    logic          pop;
    logic [Dw-1:0] rgb_q, rgb_d;
    logic          hs_q, vs_q, blank_n_q, underflow_q, underflow_d, sync_err_q, sync_err_d;

    // FIFO word layout: {sop, eop, data}
    logic [Dw+1:0] fifo_head;
    logic          fifo_full, fifo_empty, fifo_wr_ready;
    logic          head_sop;
    logic [Dw-1:0] head_data;
    logic          unused_bits;

    stream_fifo #(
        .Width (Dw + 2),
        .Aw    (FifoAw)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (in_st.valid && fifo_wr_ready),
        .wr_data  ({in_st.startofpacket, in_st.endofpacket, in_st.data}),
        .rd_en    (pop),
        .head     (fifo_head),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .wr_ready (fifo_wr_ready)
    );

    assign in_st.ready = fifo_wr_ready;
    assign head_sop    = fifo_head[Dw+1];
    assign head_data   = fifo_head[Dw-1:0];
    // eop travels through the FIFO unchecked; empty is meaningless for video.
    assign unused_bits = ^{fifo_head[Dw], in_st.empty, fifo_full};

    // Free-running raster, independent of stream state.
    always_comb begin
        h_last     = (h_cnt_q == HLast);
        frame_last = h_last && (v_cnt_q == VLast);
        visible    = (h_cnt_q < HActC) && (v_cnt_q < VActC);
        at_origin  = (h_cnt_q == '0) && (v_cnt_q == '0);
        h_cnt_d    = h_last ? '0 : h_cnt_q + 1'b1;
        v_cnt_d    = v_cnt_q;
        if (h_last) v_cnt_d = (v_cnt_q == VLast) ? '0 : v_cnt_q + 1'b1;
    end

    always_comb begin
        state_d     = state_q;
        pop         = 1'b0;
        rgb_d       = '0;
        underflow_d = 1'b0;
        sync_err_d  = 1'b0;
        unique case (state_q)
            StSeek: begin
                // Drop everything up to the next SOP, but keep the SOP itself.
                if (!fifo_empty) begin
                    if (head_sop) state_d = StWaitFrame;
                    else          pop     = 1'b1;
                end
            end
            StWaitFrame: begin
                if (frame_last) state_d = StRun;
            end
            StRun: begin
                if (visible) begin
                    if (fifo_empty) begin
                        underflow_d = 1'b1;
                        state_d     = StSeek;
                    end else if (head_sop != at_origin) begin
                        sync_err_d = 1'b1;
                        state_d    = StSeek;
                    end else begin
                        pop   = 1'b1;
                        rgb_d = head_data;
                    end
                end
            end
            default: state_d = StSeek;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            h_cnt_q     <= '0;
            v_cnt_q     <= '0;
            state_q     <= StSeek;
            rgb_q       <= '0;
            hs_q        <= 1'b1;
            vs_q        <= 1'b1;
            blank_n_q   <= 1'b0;
            underflow_q <= 1'b0;
            sync_err_q  <= 1'b0;
        end else begin
            h_cnt_q     <= h_cnt_d;
            v_cnt_q     <= v_cnt_d;
            state_q     <= state_d;
            rgb_q       <= rgb_d;
            hs_q        <= !((h_cnt_q >= HsStartC) && (h_cnt_q <= HsEndC));
            vs_q        <= !((v_cnt_q >= VsStartC) && (v_cnt_q <= VsEndC));
            blank_n_q   <= visible;
            underflow_q <= underflow_d;
            sync_err_q  <= sync_err_d;
        end
    end

    assign vga_r       = rgb_q[Dw-1 -: 8];
    assign vga_g       = rgb_q[Dw-9 -: 8];
    assign vga_b       = rgb_q[7:0];
    assign vga_hs      = hs_q;
    assign vga_vs      = vs_q;
    assign vga_blank_n = blank_n_q;
    assign underflow   = underflow_q;
    assign sync_err    = sync_err_q;

endmodule

// File: doc/vga_stream_sink.md
Name: vga_stream_sink

Overview:
Downstream consumer of the 640x480 Avalon-ST video stream produced by the frame/colour-bar sources. It buffers incoming pixels in a small synchronous FIFO and aligns each packet's start-of-packet to the top-left pixel of a free-running VGA raster. It then drives RGB, HSYNC, VSYNC and BLANK_N to the DAC. It is the last block before the board VGA pins, and it detects underflow and packet misalignment.

Parameters:
DW, 24, pixel width; packing is R in [23:16], G in [15:8], B in [7:0].
H_ACTIVE, 640, visible pixels per line.
H_FRONT, 16, horizontal front porch (clocks).
H_SYNC, 96, HSYNC pulse width (clocks).
H_BACK, 48, horizontal back porch (clocks).
V_ACTIVE, 480, visible lines.
V_FRONT, 10, vertical front porch (lines).
V_SYNC, 2, VSYNC width (lines).
V_BACK, 33, vertical back porch (lines).
FIFO_AW, 4, FIFO address width; depth is 2**FIFO_AW = 16.

Ports:
clk  in  1  pixel clock; every rising edge is one raster position.
reset  in  1  synchronous, active-low reset (0 = reset).
in_data  in  DW  stream pixel.
in_startofpacket  in  1  first pixel of a frame.
in_endofpacket  in  1  last pixel of a frame.
in_empty  in  1  ignored; always 0 for video.
in_valid  in  1  in_data is valid.
in_ready  out  1  sink can accept a word this cycle.
vga_r, vga_g, vga_b  out  8 each  pixel colour; 0 when blanked.
vga_hs  out  1  HSYNC, active-low.
vga_vs  out  1  VSYNC, active-low.
vga_blank_n  out  1  1 during the visible region.
underflow  out  1  one-cycle pulse when the FIFO is empty at a visible pixel.
sync_err  out  1  one-cycle pulse on SOP misalignment.

Behaviour:
- Reset is taken at a clk edge with reset==0. Every register clears on that edge:
  - h_cnt = 0, v_cnt = 0.
  - FIFO is emptied.
  - State machine goes to SEEK.
  - vga_r/g/b = 0, vga_hs = 1, vga_vs = 1, vga_blank_n = 0.
  - underflow = 0, sync_err = 0, in_ready = 0.
- in_ready is registered and equals !full of the next state. It becomes 1 on the first edge after reset releases.
- FIFO write: on in_valid && in_ready, store {sop, eop, data}. The FIFO holds DW+2 bits per word.
- FIFO simultaneous read and write: allowed whenever not full; the count is unchanged.
- FIFO at full: in_ready==0, so no write occurs. Upstream holds its data.
- Raster counters run freely from reset, independent of stream state:
  - h_cnt counts 0..H_TOTAL-1 (799) and wraps to 0.
  - v_cnt increments when h_cnt wraps and counts 0..V_TOTAL-1 (524), then wraps.
  - visible = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE).
- Output timing: all VGA outputs are registered with a latency of 1. Outputs at cycle t+1 reflect counter position (h, v) at cycle t.
  - vga_hs = 0 for h in [656, 751].
  - vga_vs = 0 for v in [490, 491].
  - vga_blank_n = visible.
- State machine:
  - SEEK: while the FIFO is non-empty and head.sop==0, pop and discard. When head.sop==1, go to WAIT_FRAME without popping.
  - WAIT_FRAME: pop nothing. When h_cnt==799 && v_cnt==524, go to RUN.
  - RUN, visible cycle, FIFO non-empty, normal: pop the head and register its colour onto vga_r/g/b.
  - RUN, visible cycle, FIFO empty: output black, pulse underflow, go to SEEK.
  - RUN, misaligned SOP: at position (0,0) head.sop must be 1, and at any other visible position head.sop must be 0. On violation, do not pop, output black, pulse sync_err, go to SEEK. SEEK keeps the head if its sop==1.
  - RUN, non-visible cycle: output black and pop nothing.
- in_endofpacket is carried through the FIFO but not checked. in_empty is ignored.
- When underflow and sync_err conditions coincide, underflow takes priority and only one pulse is generated.
- Reset mid-frame discards all buffered data; sync restarts from SEEK.

Decomposition:
- Shared package vga_timing_pkg holds:
  - the VGA 640x480@60 timing constants;
  - derived values H_TOTAL = 800, V_TOTAL = 525, HS_START = 656, HS_END = 751, VS_START = 490, VS_END = 491;
  - the state enum {SEEK, WAIT_FRAME, RUN}.
- One sub-module, stream_fifo: a synchronous FIFO with parameterised width and depth, providing full, empty and show-ahead head outputs. The FSM, counters and output registers stay in vga_stream_sink.

Test Plan:
1. Hold reset=0 for 5 cycles, then release -> during reset hs=1, vs=1, blank_n=0, rgb=0, in_ready=0. in_ready=1 one cycle after release. h_cnt starts at 0.
2. Free-run with no input -> hs low for exactly 96 clocks per 800-clock line, starting 657 clocks after reset release. vs low for 1600 clocks per 420000-clock frame. rgb=0 throughout.
3. Feed the colour-bar model (x<214 R=FF, x<428 G=FF, else B=FF) with sop at (0,0) -> after lock, on each visible line: rgb=FF0000 for 214 clocks, then 00FF00 for 214 clocks, then 0000FF for 212 clocks. Blanking shows 000000. No underflow or sync_err over 3 frames.
4. Push 37 words with sop=0 before the first SOP frame -> junk is discarded and never displayed. The first visible pixel is the SOP word. sync_err stays 0.
5. Drop in_valid for 40 clocks mid-line at x=300 -> exactly one underflow pulse. rgb=0 for the rest of the frame. Relock on the next SOP, with correct output from the following frame.
6. Inject sop=1 at x=100, y=5 -> one sync_err pulse and black output. Relock at the next frame start. While the FIFO is full during blanking, in_ready=0 and no word is lost or duplicated (scoreboard check).
